fib_seq_engine: RTL and testbench

FIB_SEQ_ENGINE -- requirements
Module: fib_seq_engine

---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_window.sv | 61 ++++++
 rtl/fib_seq_engine.sv | 112 +++++++++++
 tb/tb_fib_seq_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the k-bonacci sequence engine.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fib_state_e;

    localparam int ORDER_MIN = 2;
    localparam int ORDER_MAX = 4;

    // Seed window entry idx: terms 0..k-2 are zero, term k-1 is one.
    function automatic logic init_term(input int idx, input int order);
        return (idx == order - 1);
    endfunction

endpackage

// File: rtl/fib_window.sv
// fib_window: k-entry sliding window of sequence terms plus the k-input adder.
// With FIB_OVERFLOW_DETECT_EN defined, the adder is widened by two bits and
// the carry out is exported; otherwise no carry logic exists.
module fib_window #(
    parameter int WORDSIZE = 128,
    parameter int ORDER    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    output logic [WORDSIZE-1:0] head
`ifdef FIB_OVERFLOW_DETECT_EN
    ,
    output logic                carry
`endif
);
    import fib_pkg::*;

    logic [ORDER-1:0][WORDSIZE-1:0] w;
    logic [WORDSIZE-1:0]            sum;

`ifdef FIB_OVERFLOW_DETECT_EN
    // Two guard bits cover the sum of up to four WORDSIZE terms.
    logic [WORDSIZE+1:0] sum_wide;

    // Wide sum of all window entries; anything above WORDSIZE is the carry.
    always_comb begin
        sum_wide = '0;
        for (int j = 0; j < ORDER; j++)
            sum_wide = sum_wide + {2'b00, w[j]};
    end

    assign sum   = sum_wide[WORDSIZE-1:0];
    assign carry = |sum_wide[WORDSIZE+1:WORDSIZE];
`else
    // Truncated sum of all window entries.
    always_comb begin
        sum = '0;
        for (int j = 0; j < ORDER; j++)
            sum = sum + w[j];
    end
`endif

    // Seed on load; on shift drop the oldest term and append the new sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w <= '0;
        end else if (load) begin
            for (int j = 0; j < ORDER; j++)
                w[j] <= WORDSIZE'(init_term(j, ORDER));
        end else if (shift) begin
            for (int j = 0; j < ORDER - 1; j++)
                w[j] <= w[j+1];
            w[ORDER-1] <= sum;
        end
    end

    assign head = w[0];

endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: computes term n of the order-k (2..4) k-bonacci sequence,
// modulo 2^WORDSIZE. Optional sticky truncation flag under the macro
// FIB_OVERFLOW_DETECT_EN (default build: overflow tied low).
module fib_seq_engine #(
    parameter int WORDSIZE = 128,
    parameter int NBITS    = 8,
    parameter int ORDER    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NBITS-1:0]    n,
    output logic                busy,
    output logic                ready,
    output logic [WORDSIZE-1:0] result,
    output logic                overflow
);
    import fib_pkg::*;

    if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
        $error("fib_seq_engine: ORDER must lie in 2..4");
    end

    fib_state_e          state, state_nxt;
    logic [NBITS-1:0]    cnt;
    logic                accept, load, shift, finish;
    logic [WORDSIZE-1:0] head;

`ifdef FIB_OVERFLOW_DETECT_EN
    logic carry;
    logic deep;
`endif

    fib_window #(
        .WORDSIZE (WORDSIZE),
        .ORDER    (ORDER)
    ) u_win (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .head  (head)
`ifdef FIB_OVERFLOW_DETECT_EN
        ,
        .carry (carry)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and one-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                accept    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt != '0) begin
                shift = 1'b1;
            end else begin
                finish    = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remaining shifts; n is captured at accept so later n changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (accept) cnt <= n;
        else if (shift)  cnt <= cnt - NBITS'(1);
    end

    // Result only moves on entry to DONE, so partial terms never show.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        result <= '0;
        else if (finish) result <= head;
    end

`ifdef FIB_OVERFLOW_DETECT_EN
    // A shift with cnt >= k produces a term whose index is <= n; later
    // shifts compute terms past n and must not flag truncation.
    assign deep = (NBITS+3)'(cnt) >= (NBITS+3)'(ORDER);

    // Sticky truncation flag, cleared on each accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        overflow <= 1'b0;
        else if (accept)                 overflow <= 1'b0;
        else if (shift && deep && carry) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

    assign busy  = (state == LOAD) || (state == RUN);
    assign ready = (state == DONE);

endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: directed checks on four engine configurations
// (Fibonacci/128, tribonacci/128, tetranacci/128, Fibonacci/8).
module tb_fib_seq_engine;

`ifdef FIB_OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start [4];
    logic [7:0]   nin   [4];
    logic         busy  [4];
    logic         ready [4];
    logic         ovf   [4];
    logic [127:0] r2, r3, r4;
    logic [7:0]   r8;
    logic [127:0] res   [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fib_seq_engine #(.WORDSIZE(128), .NBITS(8), .ORDER(2)) d2 (
        .clk(clk), .rst(rst), .start(start[0]), .n(nin[0]),
        .busy(busy[0]), .ready(ready[0]), .result(r2), .overflow(ovf[0]));
    fib_seq_engine #(.WORDSIZE(128), .NBITS(8), .ORDER(3)) d3 (
        .clk(clk), .rst(rst), .start(start[1]), .n(nin[1]),
        .busy(busy[1]), .ready(ready[1]), .result(r3), .overflow(ovf[1]));
    fib_seq_engine #(.WORDSIZE(128), .NBITS(8), .ORDER(4)) d4 (
        .clk(clk), .rst(rst), .start(start[2]), .n(nin[2]),
        .busy(busy[2]), .ready(ready[2]), .result(r4), .overflow(ovf[2]));
    fib_seq_engine #(.WORDSIZE(8), .NBITS(8), .ORDER(2)) d8 (
        .clk(clk), .rst(rst), .start(start[3]), .n(nin[3]),
        .busy(busy[3]), .ready(ready[3]), .result(r8), .overflow(ovf[3]));

    assign res[0] = r2;
    assign res[1] = r3;
    assign res[2] = r4;
    assign res[3] = {120'd0, r8};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Plain Fibonacci F(n) mod 2^128 by pairwise iteration.
    function automatic logic [127:0] fib2(input int nn);
        logic [127:0] a = 128'd0;
        logic [127:0] b = 128'd1;
        logic [127:0] c;
        for (int i = 0; i < nn; i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return a;
    endfunction

    // Present a request on the accepting edge, then scramble n.
    task automatic launch(input int i, input int nval, input bit hold);
        @(negedge clk);
        start[i] = 1'b1;
        nin[i]   = 8'(nval);
        @(posedge clk);
        #1;
        if (!hold) start[i] = 1'b0;
        nin[i] = 8'(nval) ^ 8'h5a;
        chk($sformatf("acc_busy[%0d] n=%0d", i, nval), busy[i], 1'b1);
        chk($sformatf("acc_ready[%0d] n=%0d", i, nval), ready[i], 1'b0);
    endtask

    // Count edges until ready; check latency, result, overflow and
    // that result stays frozen and busy/ready never overlap meanwhile.
    task automatic wait_done(input int i, input int exp_lat, input logic [127:0] exp_res,
                             input bit exp_ovf, input string tag);
        int           e    = 0;
        bit           held = 1'b1;
        bit           both = 1'b0;
        logic [127:0] pre  = res[i];
        while (!ready[i] && e < 1000) begin
            @(posedge clk);
            #1;
            e++;
            if (busy[i] && ready[i]) both = 1'b1;
            if (!ready[i] && res[i] !== pre) held = 1'b0;
        end
        chk({tag, "_latency"}, e, exp_lat);
        chk({tag, "_result"}, res[i], exp_res);
        chk({tag, "_overflow"}, ovf[i], exp_ovf);
        chk({tag, "_frozen"}, held, 1'b1);
        chk({tag, "_excl"}, both, 1'b0);
    endtask

    initial begin
        logic [127:0] f255;
        f255 = fib2(255) & 128'hff;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            nin[i]   = 8'd0;
        end
        #1;
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_ready", ready[0], 1'b0);
        chk("rst_result", res[0], 128'd0);
        chk("rst_ovf", ovf[3], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        launch(0, 10, 1'b0); wait_done(0, 12, 55, 1'b0, "f10");
        launch(0, 0, 1'b0);  wait_done(0, 2, 0, 1'b0, "f0");
        launch(0, 1, 1'b0);  wait_done(0, 3, 1, 1'b0, "f1");
        launch(1, 9, 1'b0);  wait_done(1, 11, 44, 1'b0, "trib9");
        launch(2, 7, 1'b0);  wait_done(2, 9, 8, 1'b0, "tetra7");
        launch(3, 13, 1'b0); wait_done(3, 15, 233, 1'b0, "w8_n13");
        launch(3, 14, 1'b0); wait_done(3, 16, 121, OVF_EN, "w8_n14");
        launch(3, 13, 1'b0); wait_done(3, 15, 233, 1'b0, "w8_n13_again");
        launch(3, 255, 1'b0); wait_done(3, 257, f255, OVF_EN, "w8_n255");

        // DONE holds its outputs without a new start.
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_ready", ready[3], 1'b1);
        chk("done_hold_result", res[3], f255);
        chk("done_hold_ovf", ovf[3], OVF_EN);

        // Asynchronous reset in the middle of a run.
        launch(0, 20, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_ready", ready[0], 1'b0);
        chk("midrst_result", res[0], 128'd0);
        chk("midrst_w8_result", res[3], 128'd0);
        chk("midrst_w8_ovf", ovf[3], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", ready[0], 1'b0);
        chk("post_rst_busy", busy[0], 1'b0);
        launch(0, 5, 1'b0); wait_done(0, 7, 5, 1'b0, "f5_after_rst");

        // Start while busy is ignored.
        launch(0, 10, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        nin[0]   = 8'd3;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("busy_start_busy", busy[0], 1'b1);
        wait_done(0, 11, 55, 1'b0, "f10_ignore");

        // Back-to-back: held start in DONE re-accepts with no idle bubble.
        launch(0, 6, 1'b0); wait_done(0, 8, 8, 1'b0, "f6");
        launch(0, 7, 1'b1); wait_done(0, 9, 13, 1'b0, "f7_b2b");
        @(negedge clk);
        start[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
